// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the checkers board register and its move engine:
// cell codes, board geometry, the reset board layout, FSM state encoding,
// result codes and small cell-addressing helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package board_pkg;

  localparam int BOARD_N    = 8;
  localparam int CELL_W     = 3;
  localparam int BOARD_BITS = 192;

  // Cell codes; 101..111 are reserved and never legal as source or destination.
  localparam logic [2:0] CELL_EMPTY  = 3'b000;
  localparam logic [2:0] CELL_A_MAN  = 3'b001;
  localparam logic [2:0] CELL_B_MAN  = 3'b010;
  localparam logic [2:0] CELL_A_KING = 3'b011;
  localparam logic [2:0] CELL_B_KING = 3'b100;

  localparam logic RESULT_OK      = 1'b0;
  localparam logic RESULT_ILLEGAL = 1'b1;

  // Move FSM state encoding.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_CHECK      = 3'd2;
  localparam logic [2:0] ST_WRITE_TO   = 3'd3;
  localparam logic [2:0] ST_CLEAR_FROM = 3'd4;
  localparam logic [2:0] ST_CLEAR_MID  = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;
  localparam logic [2:0] ST_REJECT     = 3'd7;

  // Standard opening: men on dark squares ((x+y) odd), A on rows 0..2, B on 5..7.
  function automatic logic [BOARD_BITS-1:0] init_board_f();
    logic [BOARD_BITS-1:0] b;
    b = '0;
    for (int y = 0; y < BOARD_N; y++) begin
      for (int x = 0; x < BOARD_N; x++) begin
        if (((x + y) % 2) == 1) begin
          if (y <= 2) begin
            b[(y * BOARD_N + x) * CELL_W +: CELL_W] = CELL_A_MAN;
          end else if (y >= 5) begin
            b[(y * BOARD_N + x) * CELL_W +: CELL_W] = CELL_B_MAN;
          end
        end
      end
    end
    return b;
  endfunction

  localparam logic [BOARD_BITS-1:0] INIT_BOARD = init_board_f();

  // Bit offset of cell (x,y): (y*8 + x) * 3, at most 189, so 8 bits suffice.
  function automatic logic [7:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return {2'b00, y, x} * 8'(CELL_W);
  endfunction

  function automatic logic [2:0] cell_get(input logic [BOARD_BITS-1:0] b,
                                          input logic [2:0] x,
                                          input logic [2:0] y);
    return b[cell_idx(x, y) +: CELL_W];
  endfunction

endpackage

// File: rtl/move_rule_check.sv
// -----------------------------------------------------------------------------
// move_rule_check
// Purely combinational checkers legality rules for one requested move.
// Ports:
//   src_code, dst_code, mid_code  in  3   codes of source, destination, midpoint
//   from_x, from_y, to_x, to_y    in  3   move coordinates
//   player                        in  1   0 = player A, 1 = player B
//   legal                         out 1   move satisfies every rule
//   is_jump                       out 1   move spans two rows (capture shape)
//   promote                       out 1   legal man move landing on far row
// -----------------------------------------------------------------------------
module move_rule_check
  import board_pkg::*;
(
  input  logic [2:0] src_code,
  input  logic [2:0] dst_code,
  input  logic [2:0] mid_code,
  input  logic [2:0] from_x,
  input  logic [2:0] from_y,
  input  logic [2:0] to_x,
  input  logic [2:0] to_y,
  input  logic       player,
  output logic       legal,
  output logic       is_jump,
  output logic       promote
);

  logic [3:0] dx_s;
  logic [3:0] dy_s;
  logic [3:0] adx_s;
  logic [3:0] ady_s;
  logic       own_s;
  logic       opp_mid_s;
  logic       dir_ok_s;
  logic       shape_ok_s;

  // Signed 4-bit deltas and their magnitudes.
  always_comb begin
    dx_s  = {1'b0, to_x} - {1'b0, from_x};
    dy_s  = {1'b0, to_y} - {1'b0, from_y};
    adx_s = dx_s[3] ? (4'd0 - dx_s) : dx_s;
    ady_s = dy_s[3] ? (4'd0 - dy_s) : dy_s;
  end

  // Ownership of the source piece and man direction; reserved codes own nothing.
  always_comb begin
    own_s    = 1'b0;
    dir_ok_s = 1'b0;
    case (src_code)
      CELL_A_MAN: begin
        own_s    = (player == 1'b0);
        dir_ok_s = (dy_s[3] == 1'b0) && (dy_s != 4'd0);
      end
      CELL_A_KING: begin
        own_s    = (player == 1'b0);
        dir_ok_s = 1'b1;
      end
      CELL_B_MAN: begin
        own_s    = (player == 1'b1);
        dir_ok_s = dy_s[3];
      end
      CELL_B_KING: begin
        own_s    = (player == 1'b1);
        dir_ok_s = 1'b1;
      end
      default: begin
        own_s    = 1'b0;
        dir_ok_s = 1'b0;
      end
    endcase
  end

  // The jumped-over cell must hold an opponent man or king.
  always_comb begin
    opp_mid_s = 1'b0;
    if (player == 1'b0) begin
      opp_mid_s = (mid_code == CELL_B_MAN) || (mid_code == CELL_B_KING);
    end else begin
      opp_mid_s = (mid_code == CELL_A_MAN) || (mid_code == CELL_A_KING);
    end
  end

  // Diagonal of length 1, or length 2 over an opponent; from==to fails both.
  always_comb begin
    shape_ok_s = (adx_s == ady_s) &&
                 ((ady_s == 4'd1) || ((ady_s == 4'd2) && opp_mid_s));
    legal      = own_s && (dst_code == CELL_EMPTY) && shape_ok_s && dir_ok_s;
    is_jump    = (ady_s == 4'd2);
    promote    = legal &&
                 (((src_code == CELL_A_MAN) && (to_y == 3'd7)) ||
                  ((src_code == CELL_B_MAN) && (to_y == 3'd0)));
  end

endmodule

// File: rtl/board_move_engine.sv
// -----------------------------------------------------------------------------
// board_move_engine
// Owns the 192-bit checkers board (64 cells x 3 bits, idx = y*8+x). Accepts
// move requests over valid/ready, checks legality, applies the move as
// sequential cell writes (destination, source, captured piece) and reports
// the outcome with a one-cycle done pulse. Also supports direct cell writes
// while idle. Intermediate board states are visible while a move is applied;
// readers should refresh on board_changed.
// Ports:
//   clk, rst                     in       clock, async active-high reset
//   move_valid / move_ready      in/out   move request handshake
//   move_player                  in  1    0 = A, 1 = B
//   from_x, from_y, to_x, to_y   in  3    move coordinates
//   wr_en, wr_x, wr_y, wr_status in       direct cell write (idle only)
//   board                        out 192  current board
//   busy                         out 1    FSM not idle
//   done, result                 out 1    move finished / 0 OK, 1 ILLEGAL
//   captured, promoted           out 1    valid while done=1
//   board_changed                out 1    pulse after any board modification
// -----------------------------------------------------------------------------
module board_move_engine
  import board_pkg::*;
#(
  parameter int BOARD_N = 8,
  parameter int CELL_W  = 3,
  parameter logic [191:0] INIT_BOARD = board_pkg::INIT_BOARD
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                move_valid,
  output logic                                move_ready,
  input  logic                                move_player,
  input  logic [2:0]                          from_x,
  input  logic [2:0]                          from_y,
  input  logic [2:0]                          to_x,
  input  logic [2:0]                          to_y,
  input  logic                                wr_en,
  input  logic [2:0]                          wr_x,
  input  logic [2:0]                          wr_y,
  input  logic [2:0]                          wr_status,
  output logic [BOARD_N*BOARD_N*CELL_W-1:0]   board,
  output logic                                busy,
  output logic                                done,
  output logic                                result,
  output logic                                captured,
  output logic                                promoted,
  output logic                                board_changed
);

  logic [BOARD_N*BOARD_N*CELL_W-1:0] board_r;
  logic [2:0] state_r;
  logic       player_r;
  logic [2:0] fx_r, fy_r, tx_r, ty_r;
  logic [2:0] src_r, dst_r, mid_r;
  logic       jump_r, promote_r;
  logic       done_r, result_r, captured_r, promoted_r, board_changed_r;

  logic [2:0] mid_x_s, mid_y_s;
  logic       legal_s, is_jump_s, promote_s;
  logic [2:0] land_code_s;

  assign mid_x_s = 3'(({1'b0, fx_r} + {1'b0, tx_r}) >> 3'd1);
  assign mid_y_s = 3'(({1'b0, fy_r} + {1'b0, ty_r}) >> 3'd1);

  move_rule_check u_rule (
    .src_code (src_r),
    .dst_code (dst_r),
    .mid_code (mid_r),
    .from_x   (fx_r),
    .from_y   (fy_r),
    .to_x     (tx_r),
    .to_y     (ty_r),
    .player   (player_r),
    .legal    (legal_s),
    .is_jump  (is_jump_s),
    .promote  (promote_s)
  );

  // Code written to the destination: a promoted man becomes its side's king.
  always_comb begin
    land_code_s = src_r;
    if (promote_r) begin
      land_code_s = (src_r == CELL_A_MAN) ? CELL_A_KING : CELL_B_KING;
    end else begin
      land_code_s = src_r;
    end
  end

  // Move FSM, request latch, board writes and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_r         <= INIT_BOARD;
      state_r         <= ST_IDLE;
      player_r        <= 1'b0;
      fx_r            <= 3'd0;
      fy_r            <= 3'd0;
      tx_r            <= 3'd0;
      ty_r            <= 3'd0;
      src_r           <= CELL_EMPTY;
      dst_r           <= CELL_EMPTY;
      mid_r           <= CELL_EMPTY;
      jump_r          <= 1'b0;
      promote_r       <= 1'b0;
      done_r          <= 1'b0;
      result_r        <= RESULT_OK;
      captured_r      <= 1'b0;
      promoted_r      <= 1'b0;
      board_changed_r <= 1'b0;
    end else begin
      done_r          <= 1'b0;
      board_changed_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A direct write wins over a move request; move_ready is low then.
          if (wr_en) begin
            board_r[cell_idx(wr_x, wr_y) +: CELL_W] <= wr_status;
            board_changed_r <= 1'b1;
          end else if (move_valid) begin
            player_r <= move_player;
            fx_r     <= from_x;
            fy_r     <= from_y;
            tx_r     <= to_x;
            ty_r     <= to_y;
            state_r  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          src_r   <= cell_get(board_r, fx_r, fy_r);
          dst_r   <= cell_get(board_r, tx_r, ty_r);
          mid_r   <= cell_get(board_r, mid_x_s, mid_y_s);
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          if (legal_s) begin
            jump_r    <= is_jump_s;
            promote_r <= promote_s;
            state_r   <= ST_WRITE_TO;
          end else begin
            done_r     <= 1'b1;
            result_r   <= RESULT_ILLEGAL;
            captured_r <= 1'b0;
            promoted_r <= 1'b0;
            state_r    <= ST_REJECT;
          end
        end
        ST_WRITE_TO: begin
          board_r[cell_idx(tx_r, ty_r) +: CELL_W] <= land_code_s;
          state_r <= ST_CLEAR_FROM;
        end
        ST_CLEAR_FROM: begin
          board_r[cell_idx(fx_r, fy_r) +: CELL_W] <= CELL_EMPTY;
          if (jump_r) begin
            state_r <= ST_CLEAR_MID;
          end else begin
            done_r          <= 1'b1;
            result_r        <= RESULT_OK;
            captured_r      <= 1'b0;
            promoted_r      <= promote_r;
            board_changed_r <= 1'b1;
            state_r         <= ST_DONE;
          end
        end
        ST_CLEAR_MID: begin
          board_r[cell_idx(mid_x_s, mid_y_s) +: CELL_W] <= CELL_EMPTY;
          done_r          <= 1'b1;
          result_r        <= RESULT_OK;
          captured_r      <= 1'b1;
          promoted_r      <= promote_r;
          board_changed_r <= 1'b1;
          state_r         <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_REJECT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready    = (state_r == ST_IDLE) && !wr_en;
  assign busy          = (state_r != ST_IDLE);
  assign board         = board_r;
  assign done          = done_r;
  assign result        = result_r;
  assign captured      = captured_r;
  assign promoted      = promoted_r;
  assign board_changed = board_changed_r;

endmodule

// File: tb/tb_board_move_engine.sv
// -----------------------------------------------------------------------------
// tb_board_move_engine
// Scoreboard bench: each move pushes its expected outcome (result, captured,
// promoted, done latency) when driven; the entry is popped and compared when
// the DUT pulses done. The bench keeps its own board model for board checks.
// -----------------------------------------------------------------------------
module tb_board_move_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         move_valid;
  logic         move_ready;
  logic         move_player;
  logic [2:0]   from_x, from_y, to_x, to_y;
  logic         wr_en;
  logic [2:0]   wr_x, wr_y, wr_status;
  logic [191:0] board;
  logic         busy, done, result, captured, promoted, board_changed;

  typedef struct packed {
    logic       res;
    logic       capt;
    logic       prom;
    logic [3:0] lat;
  } exp_t;

  exp_t         sb_q[$];
  logic [191:0] model;
  logic [191:0] init_model;
  int           n_vec = 0;
  int           n_err = 0;

  board_move_engine dut (
    .clk           (clk),
    .rst           (rst),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_player   (move_player),
    .from_x        (from_x),
    .from_y        (from_y),
    .to_x          (to_x),
    .to_y          (to_y),
    .wr_en         (wr_en),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_status     (wr_status),
    .board         (board),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .captured      (captured),
    .promoted      (promoted),
    .board_changed (board_changed)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_model(input int x, input int y, input logic [2:0] v);
    logic [7:0] idx;
    idx = 8'((y * 8 + x) * 3);
    model[idx +: 3] = v;
  endtask

  task automatic build_init();
    model = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (((x + y) % 2) == 1) begin
          if (y <= 2) set_model(x, y, 3'b001);
          else if (y >= 5) set_model(x, y, 3'b010);
        end
      end
    end
    init_model = model;
  endtask

  task automatic do_write(input int x, input int y, input logic [2:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_x = 3'(x); wr_y = 3'(y); wr_status = v;
    @(negedge clk);
    wr_en = 1'b0;
    set_model(x, y, v);
    check_val("wr_changed", {191'd0, board_changed}, 192'd1);
    check_val("wr_board", board, model);
  endtask

  // Drive one move, scramble the request after acceptance, then wait for done.
  task automatic do_move(input string tag, input logic p, input int fx, input int fy,
                         input int tx, input int ty, input logic res, input logic capt,
                         input logic prom, input int lat, input logic [2:0] land);
    exp_t e;
    int   cyc;
    int   changes;
    logic seen;
    @(negedge clk);
    check_val({tag, "_ready"}, {191'd0, move_ready}, 192'd1);
    move_valid = 1'b1; move_player = p;
    from_x = 3'(fx); from_y = 3'(fy); to_x = 3'(tx); to_y = 3'(ty);
    sb_q.push_back('{res: res, capt: capt, prom: prom, lat: 4'(lat)});
    @(negedge clk);
    move_valid = 1'b0; move_player = ~p;
    from_x = 3'd7; from_y = 3'd7; to_x = 3'd0; to_y = 3'd0;
    check_val({tag, "_busy"}, {191'd0, busy}, 192'd1);
    cyc = 1; changes = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      if (board_changed) changes++;
      if (done) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      check_val({tag, "_timeout"}, 192'd0, 192'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_result"}, {191'd0, result}, {191'd0, e.res});
      check_val({tag, "_captured"}, {191'd0, captured}, {191'd0, e.capt});
      check_val({tag, "_promoted"}, {191'd0, promoted}, {191'd0, e.prom});
      check_val({tag, "_latency"}, 192'(cyc), 192'(e.lat));
      check_val({tag, "_changed"}, 192'(changes), (e.res == 1'b0) ? 192'd1 : 192'd0);
    end
    if (res == 1'b0) begin
      set_model(tx, ty, land);
      set_model(fx, fy, 3'b000);
      if (capt) set_model((fx + tx) / 2, (fy + ty) / 2, 3'b000);
    end
    @(negedge clk);
    check_val({tag, "_board"}, board, model);
    check_val({tag, "_idle"}, {190'd0, busy, done}, 192'd0);
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; move_valid = 1'b0; move_player = 1'b0;
    from_x = 3'd0; from_y = 3'd0; to_x = 3'd0; to_y = 3'd0;
    wr_en = 1'b0; wr_x = 3'd0; wr_y = 3'd0; wr_status = 3'd0;
    build_init();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: reset state
    check_val("rst_board", board, init_model);
    check_val("rst_ready", {191'd0, move_ready}, 192'd1);
    check_val("rst_flags", {186'd0, busy, done, result, captured, promoted, board_changed}, 192'd0);

    // 2: simple A move
    do_move("a_simple", 1'b0, 1, 2, 2, 3, 1'b0, 1'b0, 1'b0, 5, 3'b001);
    // 3: backward A man, then B moving an A piece
    do_move("a_backward", 1'b0, 2, 3, 1, 2, 1'b1, 1'b0, 1'b0, 3, 3'b000);
    do_move("b_not_owner", 1'b1, 2, 3, 1, 2, 1'b1, 1'b0, 1'b0, 3, 3'b000);
    // 4: jump with capture
    do_write(3, 4, 3'b010);
    do_write(4, 5, 3'b000);
    do_move("a_jump", 1'b0, 2, 3, 4, 5, 1'b0, 1'b1, 1'b0, 6, 3'b001);
    // 5: promotion, then king moves both ways without promotion
    do_write(1, 6, 3'b001);
    do_write(0, 7, 3'b000);
    do_move("a_promote", 1'b0, 1, 6, 0, 7, 1'b0, 1'b0, 1'b1, 5, 3'b011);
    do_move("king_back", 1'b0, 0, 7, 1, 6, 1'b0, 1'b0, 1'b0, 5, 3'b011);
    do_move("king_fwd", 1'b0, 1, 6, 0, 7, 1'b0, 1'b0, 1'b0, 5, 3'b011);
    // Further rule boundaries
    do_move("dst_occupied", 1'b0, 2, 1, 3, 2, 1'b1, 1'b0, 1'b0, 3, 3'b000);
    do_move("not_diag", 1'b0, 3, 2, 3, 3, 1'b1, 1'b0, 1'b0, 3, 3'b000);
    do_move("jump_empty", 1'b0, 3, 2, 5, 4, 1'b1, 1'b0, 1'b0, 3, 3'b000);
    do_move("b_simple", 1'b1, 2, 5, 3, 4, 1'b0, 1'b0, 1'b0, 5, 3'b010);
    do_write(6, 3, 3'b101);
    do_move("reserved_src", 1'b0, 6, 3, 7, 4, 1'b1, 1'b0, 1'b0, 3, 3'b000);

    // 6: reset during cycle 4 of a legal move
    @(negedge clk);
    move_valid = 1'b1; move_player = 1'b0;
    from_x = 3'd3; from_y = 3'd2; to_x = 3'd4; to_y = 3'd3;
    @(negedge clk);
    move_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    model = init_model;
    check_val("midrst_board", board, init_model);
    check_val("midrst_flags", {190'd0, busy, done}, 192'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_ready", {191'd0, move_ready}, 192'd1);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("midrst_no_done", 192'(done_cnt), 192'd0);

    // 6b: write and move request together: write happens, move not accepted
    @(negedge clk);
    move_valid = 1'b1; move_player = 1'b0;
    from_x = 3'd1; from_y = 3'd2; to_x = 3'd0; to_y = 3'd3;
    wr_en = 1'b1; wr_x = 3'd4; wr_y = 3'd3; wr_status = 3'b001;
    #1;
    check_val("wrmv_ready", {191'd0, move_ready}, 192'd0);
    @(negedge clk);
    move_valid = 1'b0; wr_en = 1'b0;
    set_model(4, 3, 3'b001);
    check_val("wrmv_busy", {191'd0, busy}, 192'd0);
    check_val("wrmv_changed", {191'd0, board_changed}, 192'd1);
    check_val("wrmv_board", board, model);
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_val("wrmv_no_done", 192'(done_cnt), 192'd0);
    do_move("after_rst", 1'b0, 1, 2, 0, 3, 1'b0, 1'b0, 1'b0, 5, 3'b001);

    check_val("sb_empty", 192'(sb_q.size()), 192'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/board_move_engine.md
Name: board_move_engine

Overview:
Owns the 192-bit checkers board register, which packs 64 cells at 3 bits each. The engine is the writer side of the board interface; the VGA board drawer and the status lookup are the readers. It accepts move requests over a valid/ready handshake, checks legality, and applies the move as sequential cell writes, including capture and promotion. When finished it reports a result and pulses board_changed so the display refreshes.

Parameters:
BOARD_N, 8, cells per side
CELL_W, 3, bits per cell
INIT_BOARD, standard layout (see Behaviour), board value loaded at reset

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  asynchronous, active-high reset
move_valid  in  1  move request present
move_ready  out  1  engine can accept a move
move_player  in  1  0 = player A, 1 = player B
from_x, from_y  in  3 each  source cell, 0..7
to_x, to_y  in  3 each  destination cell, 0..7
wr_en  in  1  direct cell write (test/setup)
wr_x, wr_y  in  3 each  direct write cell
wr_status  in  3  direct write value
board  out  192  current board
busy  out  1  FSM not in IDLE
done  out  1  1-cycle pulse, move finished
result  out  1  0 = OK, 1 = ILLEGAL; valid while done=1
captured  out  1  valid while done=1
promoted  out  1  valid while done=1
board_changed  out  1  1-cycle pulse after any board modification

Behaviour:
- Cell layout: idx = y*8 + x; cell bits are board[idx*3+2 : idx*3].
- Cell codes: 000 empty; 001 A man; 010 B man; 011 A king; 100 B king; 101–111 reserved, never legal as a source or destination.
- INIT_BOARD: cells with (x+y) odd hold A men in y=0..2 and B men in y=5..7; every other cell is 000.
- Reset (asynchronous): board=INIT_BOARD, FSM=IDLE. Outputs: move_ready=1; busy, done, result, captured, promoted, board_changed all 0.
- move_ready=1 only in IDLE with wr_en=0. A move is accepted when move_valid&&move_ready; all request fields are latched at acceptance. Changes to move_valid or the inputs after acceptance are ignored.
- wr_en in IDLE writes one cell on that edge and pulses board_changed on the next cycle. wr_en outside IDLE is ignored.
- FSM sequence, where cycle 0 is the acceptance edge:
  - FETCH (cycle 1): read the src, dst and mid cells. mid = ((fx+tx)/2, (fy+ty)/2).
  - CHECK (cycle 2): go to WRITE_TO if legal, else REJECT.
  - WRITE_TO (3): dst = src code, upgraded to king if promoted.
  - CLEAR_FROM (4): src = 000.
  - CLEAR_MID (5): mid = 000; jump moves only.
  - DONE: done=1, result=0, board_changed=1, then IDLE. A simple move reaches DONE at cycle 5; a jump at cycle 6.
  - REJECT (3): done=1, result=1, board unchanged, no board_changed pulse, then IDLE.
- Legality; every condition must hold:
  - src belongs to move_player. A owns 001/011; B owns 010/100.
  - dst == 000.
  - |dx| == |dy|, where dx = tx-fx and dy = ty-fy as signed 4-bit values.
  - Simple move: |dy|==1.
  - Jump: |dy|==2, and mid holds an opponent piece (man or king).
  - Direction: A men need dy>0, B men need dy<0; kings may move either way.
  - from==to is illegal.
- Promotion: an A man landing on y=7 becomes 011; a B man landing on y=0 becomes 100. Moving a king never sets promoted.
- captured=1 only for a legal jump. captured and promoted are 0 on REJECT.
- Intermediate board states may be visible for up to 3 cycles. Readers must use board_changed as the update marker.
- Reset mid-move aborts the move: board returns to INIT_BOARD and no done pulse is issued.

Decomposition:
- board_pkg holds:
  - cell code constants
  - CELL_W, BOARD_N, BOARD_BITS=192
  - INIT_BOARD
  - the FSM state encoding
  - RESULT_OK / RESULT_ILLEGAL
- Sub-module move_rule_check (combinational): inputs are the src/dst/mid codes, the coordinates and the player. Outputs are legal, is_jump and promote. This keeps the legality rules testable in isolation. Cell read/write muxing stays in board_move_engine.

Test Plan:
1. Reset, then read board -> board==INIT_BOARD, move_ready=1, busy=0.
2. A moves (1,2)->(2,3) -> done at cycle 5, result=0; cell(1,2)=000, cell(2,3)=001; board_changed pulses; captured=0.
3. After test 2, A moves (2,3)->(1,2) (backward man) -> done at cycle 3, result=1, board unchanged, no board_changed pulse. Also: B requests to move the A piece at (2,3) -> result=1.
4. Direct writes set (3,4)=010 and (4,5)=000; A jumps (2,3)->(4,5) -> done at cycle 6, result=0, captured=1; cells (2,3) and (3,4) =000, (4,5)=001.
5. Direct writes set (1,6)=001 and (0,7)=000; A moves (1,6)->(0,7) -> cell(0,7)=011, promoted=1.
6. Assert rst in cycle 4 of a legal move -> board==INIT_BOARD immediately, no done pulse, move_ready=1 after release. Also: move_valid with wr_en=1 in IDLE -> the write occurs and the move is not accepted that cycle.
